// File: rtl/rv_mc_ctrl.sv
// rv_mc_ctrl: multi-cycle control FSM for the RV32IM core.
//
// Sequences each instruction through FETCH, DECODE, EXEC, (MDWAIT | MEM), WB
// and steers one shared ALU, the register file, the PC and both memory ports.
// Illegal encodings park the core in TRAP until reset.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   op, func          decoded opcode and {funct7, funct3}; valid from DECODE on
//   br_taken          ALU compare result for the current branch
//   imem_ack          instruction memory data valid
//   dmem_ack          data memory access complete
//   md_done           mul/div result valid (sampled only in MDWAIT)
//   imem_req, ir_we   instruction fetch request / instruction register load
//   dmem_req, dmem_we data memory request / store
//   md_start          one-cycle mul/div start pulse
//   alu_a_pc          ALU operand A = PC
//   alu_b_imm         ALU operand B = immediate
//   rf_we, wb_sel     register write enable / source (ALU, MEM, PC+4, IMM)
//   pc_we, pc_sel     PC write enable / source (PC+4, PC+imm, (rs1+imm)&~1)
//   illegal           sticky illegal-instruction flag
//   retired           one-cycle pulse per completed instruction
//   instret           retired-instruction count, wraps to zero
//   state             current FSM state, for debug
module rv_mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [9:0]       func,
  input  logic             br_taken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             md_done,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             md_start,
  output logic             alu_a_pc,
  output logic             alu_b_imm,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             illegal,
  output logic             retired,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MDWAIT = 3'd4,
    S_MEM    = 3'd5,
    S_WB     = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  // Instruction class after the legality check; C_BAD marks an illegal encoding.
  typedef enum logic [3:0] {
    C_R, C_MD, C_IALU, C_LOAD, C_STORE, C_BR,
    C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD
  } cls_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  state_t           state_q, state_d;
  cls_t             cls;
  logic [CNT_W-1:0] instret_q;
  logic             illegal_q;
  logic [2:0]       f3;
  logic [6:0]       f7;

  assign f3 = func[2:0];
  assign f7 = func[9:3];

  // Classify the instruction; anything outside the RV32IM encodings is C_BAD.
  // NOTE: every variable written in this block gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    cls = C_BAD;
    unique case (op)
      OP_R: begin
        if (f7 == F7_BASE)                                    cls = C_R;
        else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) cls = C_R;
        else if (f7 == F7_MD)                                 cls = C_MD;
      end
      OP_IALU: begin
        // funct7 only qualifies the shift-immediates.
        if (f3 == 3'b001)      cls = (f7 == F7_BASE) ? C_IALU : C_BAD;
        else if (f3 == 3'b101) cls = (f7 == F7_BASE || f7 == F7_ALT) ? C_IALU : C_BAD;
        else                   cls = C_IALU;
      end
      OP_LOAD:   if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) cls = C_LOAD;
      OP_STORE:  if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010)  cls = C_STORE;
      OP_BRANCH: if (f3 != 3'b010 && f3 != 3'b011)                  cls = C_BR;
      OP_JALR:   if (f3 == 3'b000)                                  cls = C_JALR;
      OP_JAL:    cls = C_JAL;
      OP_LUI:    cls = C_LUI;
      OP_AUIPC:  cls = C_AUIPC;
      default:   cls = C_BAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retired)                              instret_q <= instret_q + CNT_W'(1);
      if (state_q == S_DECODE && cls == C_BAD)  illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    md_start  = 1'b0;
    alu_a_pc  = 1'b0;
    alu_b_imm = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    retired   = 1'b0;
    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
        if (imem_ack) state_d = S_DECODE;
      end
      S_DECODE: state_d = (cls == C_BAD) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        unique case (cls)
          C_MD: begin
            md_start = 1'b1;
            state_d  = S_MDWAIT;
          end
          C_LOAD, C_STORE: begin
            alu_b_imm = 1'b1;
            state_d   = S_MEM;
          end
          C_BR: begin
            pc_we   = 1'b1;
            pc_sel  = br_taken ? 2'd1 : 2'd0;
            retired = 1'b1;
            state_d = S_FETCH;
          end
          C_JAL, C_AUIPC: begin
            alu_a_pc  = 1'b1;
            alu_b_imm = 1'b1;
            state_d   = S_WB;
          end
          C_IALU, C_JALR: begin
            alu_b_imm = 1'b1;
            state_d   = S_WB;
          end
          default: state_d = S_WB;
        endcase
      end
      // md_done is looked at only here, so a result flagged in the start cycle
      // is not mistaken for completion.
      S_MDWAIT: if (md_done) state_d = S_WB;
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == C_STORE);
        if (dmem_ack) begin
          if (cls == C_STORE) begin
            pc_we   = 1'b1;
            retired = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        retired = 1'b1;
        state_d = S_FETCH;
        unique case (cls)
          C_LOAD: wb_sel = 2'd1;
          C_JAL: begin
            wb_sel = 2'd2;
            pc_sel = 2'd1;
          end
          C_JALR: begin
            wb_sel = 2'd2;
            pc_sel = 2'd2;
          end
          C_LUI:   wb_sel = 2'd3;
          default: wb_sel = 2'd0;
        endcase
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_RESET;
    endcase
  end

  assign illegal = illegal_q;
  assign instret = instret_q;
  assign state   = state_q;

endmodule
